// File: rtl/matrix_stream_reader.sv
// matrix_stream_reader: snapshots a flat 5x5 row-major matrix on start and
// streams the live r x c region one element per valid/ready handshake.
module matrix_stream_reader #(
    parameter int unsigned DATA_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [2:0]            r_in,
    input  logic [2:0]            c_in,
    input  logic [DATA_WIDTH-1:0] data_in_0,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    input  logic [DATA_WIDTH-1:0] data_in_3,
    input  logic [DATA_WIDTH-1:0] data_in_4,
    input  logic [DATA_WIDTH-1:0] data_in_5,
    input  logic [DATA_WIDTH-1:0] data_in_6,
    input  logic [DATA_WIDTH-1:0] data_in_7,
    input  logic [DATA_WIDTH-1:0] data_in_8,
    input  logic [DATA_WIDTH-1:0] data_in_9,
    input  logic [DATA_WIDTH-1:0] data_in_10,
    input  logic [DATA_WIDTH-1:0] data_in_11,
    input  logic [DATA_WIDTH-1:0] data_in_12,
    input  logic [DATA_WIDTH-1:0] data_in_13,
    input  logic [DATA_WIDTH-1:0] data_in_14,
    input  logic [DATA_WIDTH-1:0] data_in_15,
    input  logic [DATA_WIDTH-1:0] data_in_16,
    input  logic [DATA_WIDTH-1:0] data_in_17,
    input  logic [DATA_WIDTH-1:0] data_in_18,
    input  logic [DATA_WIDTH-1:0] data_in_19,
    input  logic [DATA_WIDTH-1:0] data_in_20,
    input  logic [DATA_WIDTH-1:0] data_in_21,
    input  logic [DATA_WIDTH-1:0] data_in_22,
    input  logic [DATA_WIDTH-1:0] data_in_23,
    input  logic [DATA_WIDTH-1:0] data_in_24,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [2:0]            out_row,
    output logic [2:0]            out_col,
    output logic                  out_last_col,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  isValid
);

    localparam int unsigned N_ELEM = 25;
    localparam int unsigned DIM    = 5;
    localparam int unsigned IDX_W  = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [DATA_WIDTH-1:0] w_data_in [N_ELEM];
    logic [DATA_WIDTH-1:0] r_buf     [N_ELEM];

    logic [2:0]            r_row, r_col, r_rows, r_cols;
    logic [2:0]            w_nxt_row, w_nxt_col, w_nxt_rows, w_nxt_cols;
    logic [IDX_W-1:0]      w_nxt_idx;
    logic                  w_legal, w_last_col, w_last_row, w_hs, w_load;
    logic [DATA_WIDTH-1:0] w_nxt_data;
    logic                  w_nxt_is_valid, w_nxt_last_col, w_nxt_last;

    logic                  r_out_valid, r_out_last_col, r_out_last;
    logic                  r_busy, r_done, r_is_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    assign w_data_in[0]  = data_in_0;
    assign w_data_in[1]  = data_in_1;
    assign w_data_in[2]  = data_in_2;
    assign w_data_in[3]  = data_in_3;
    assign w_data_in[4]  = data_in_4;
    assign w_data_in[5]  = data_in_5;
    assign w_data_in[6]  = data_in_6;
    assign w_data_in[7]  = data_in_7;
    assign w_data_in[8]  = data_in_8;
    assign w_data_in[9]  = data_in_9;
    assign w_data_in[10] = data_in_10;
    assign w_data_in[11] = data_in_11;
    assign w_data_in[12] = data_in_12;
    assign w_data_in[13] = data_in_13;
    assign w_data_in[14] = data_in_14;
    assign w_data_in[15] = data_in_15;
    assign w_data_in[16] = data_in_16;
    assign w_data_in[17] = data_in_17;
    assign w_data_in[18] = data_in_18;
    assign w_data_in[19] = data_in_19;
    assign w_data_in[20] = data_in_20;
    assign w_data_in[21] = data_in_21;
    assign w_data_in[22] = data_in_22;
    assign w_data_in[23] = data_in_23;
    assign w_data_in[24] = data_in_24;

    // Dimension legality, end-of-row/end-of-matrix and handshake decode.
    assign w_legal    = (r_in != 3'd0) && (r_in <= 3'(DIM)) &&
                        (c_in != 3'd0) && (c_in <= 3'(DIM));
    assign w_last_col = (r_col == (r_cols - 3'd1));
    assign w_last_row = (r_row == (r_rows - 3'd1));
    assign w_hs       = (r_state == S_SEND) && out_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; en low aborts from any state, including on the final handshake.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (en && w_legal) w_next_state = S_SEND;
            S_SEND: begin
                if (!en) begin
                    w_next_state = S_IDLE;
                end else if (w_hs && w_last_col && w_last_row) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: if (!en) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic: next values for the position counters and registered outputs.
    always_comb begin
        w_nxt_row      = r_row;
        w_nxt_col      = r_col;
        w_nxt_rows     = r_rows;
        w_nxt_cols     = r_cols;
        w_load         = 1'b0;
        w_nxt_is_valid = r_is_valid;
        w_nxt_data     = r_out_data;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_nxt_is_valid = w_legal;
                    if (w_legal) begin
                        w_load     = 1'b1;
                        w_nxt_row  = 3'd0;
                        w_nxt_col  = 3'd0;
                        w_nxt_rows = r_in;
                        w_nxt_cols = c_in;
                    end
                end
            end
            S_SEND: begin
                if (en && w_hs) begin
                    if (!w_last_col) begin
                        w_nxt_col = r_col + 3'd1;
                    end else if (!w_last_row) begin
                        w_nxt_col = 3'd0;
                        w_nxt_row = r_row + 3'd1;
                    end
                end
            end
            default: ;
        endcase
        if (!en) begin
            w_nxt_is_valid = 1'b1;
        end
        w_nxt_idx = IDX_W'(IDX_W'(w_nxt_row) * IDX_W'(DIM) + IDX_W'(w_nxt_col));
        if (w_next_state == S_SEND) begin
            w_nxt_data = w_load ? w_data_in[w_nxt_idx] : r_buf[w_nxt_idx];
        end
        w_nxt_last_col = (w_next_state == S_SEND) && (w_nxt_col == (w_nxt_cols - 3'd1));
        w_nxt_last     = w_nxt_last_col && (w_nxt_row == (w_nxt_rows - 3'd1));
    end

    // Snapshot buffer, position counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_ELEM; i++) begin
                r_buf[i] <= '0;
            end
            r_row          <= 3'd0;
            r_col          <= 3'd0;
            r_rows         <= 3'd0;
            r_cols         <= 3'd0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_last_col <= 1'b0;
            r_out_last     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_is_valid     <= 1'b1;
        end else begin
            if (w_load) begin
                for (int i = 0; i < N_ELEM; i++) begin
                    r_buf[i] <= w_data_in[i];
                end
            end
            r_row          <= w_nxt_row;
            r_col          <= w_nxt_col;
            r_rows         <= w_nxt_rows;
            r_cols         <= w_nxt_cols;
            r_out_valid    <= (w_next_state == S_SEND);
            r_out_data     <= w_nxt_data;
            r_out_last_col <= w_nxt_last_col;
            r_out_last     <= w_nxt_last;
            r_busy         <= (w_next_state == S_SEND);
            r_done         <= (w_next_state == S_DONE);
            r_is_valid     <= w_nxt_is_valid;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_row      = r_row;
    assign out_col      = r_col;
    assign out_last_col = r_out_last_col;
    assign out_last     = r_out_last;
    assign busy         = r_busy;
    assign done         = r_done;
    assign isValid      = r_is_valid;

endmodule
